// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, issues word fetches to instruction memory and
// fills the IF/ID pipeline register. It handles redirects (PCSrc) and decode
// stalls.
//
// Memory handshake: a request is outstanding while IMemReq=1. IMemAddr stays
// frozen until the cycle in which IMemValid=1 (that can be the first request
// cycle). IMemRData is sampled only in that cycle. At most one request is
// outstanding at any time.
//
// Decode handshake: ValidD=1 with Stall=0 means decode takes InstrD at the
// next edge. While Stall=1, the IF/ID register holds, except on a flush.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Stall,
  input  logic        PCSrc,
  input  logic [31:0] PCTarget,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemValid,
  input  logic [31:0] IMemRData,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,  // no request; next cycle starts one at PC
    S_WAIT = 2'd1,  // request for ReqAddr outstanding
    S_HOLD = 2'd2,  // word returned under stall, parked in the hold buffer
    S_DROP = 2'd3   // stale request still outstanding after a redirect
  } state_t;

  state_t      r_state;
  logic        r_req;
  logic [31:0] r_pc;
  logic [31:0] r_req_addr;
  logic [31:0] r_hold;
  logic [31:0] r_instr_d;
  logic [31:0] r_pcd;
  logic [31:0] r_pcp4d;
  logic        r_valid_d;

  logic [31:0] w_target;
  logic [31:0] w_req_plus4;
  logic [31:0] w_pc_plus4;

  // Redirect target is forced to word alignment; sequential adds wrap at 2^32.
  assign w_target    = PCTarget & 32'hFFFF_FFFC;
  assign w_req_plus4 = r_req_addr + 32'd4;
  assign w_pc_plus4  = r_pc + 32'd4;

  // Fetch FSM, PC, request address, hold buffer and IF/ID register.
  // Decisions use this priority: rst > PCSrc > Stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_req      <= 1'b0;
      r_pc       <= RESET_PC;
      r_req_addr <= RESET_PC;
      r_hold     <= '0;
      r_instr_d  <= NOP_INSTR;
      r_pcd      <= '0;
      r_pcp4d    <= '0;
      r_valid_d  <= 1'b0;
    end else begin
      // A redirect kills whatever decode holds, even under stall.
      if (PCSrc) begin
        r_valid_d <= 1'b0;
        r_instr_d <= NOP_INSTR;
      end
      case (r_state)
        S_IDLE: begin
          r_state <= S_WAIT;
          r_req   <= 1'b1;
          if (PCSrc) begin
            r_pc       <= w_target;
            r_req_addr <= w_target;
          end else begin
            r_req_addr <= r_pc;
          end
        end
        S_WAIT: begin
          if (PCSrc) begin
            r_pc <= w_target;
            if (IMemValid) begin
              // The returned word is on the wrong path; start the target fetch now.
              r_req_addr <= w_target;
            end else begin
              // The old request must finish first, so keep its address frozen.
              r_state <= S_DROP;
            end
          end else if (IMemValid) begin
            if (Stall) begin
              r_hold  <= IMemRData;
              r_state <= S_HOLD;
              r_req   <= 1'b0;
            end else begin
              r_instr_d  <= IMemRData;
              r_pcd      <= r_req_addr;
              r_pcp4d    <= w_req_plus4;
              r_valid_d  <= 1'b1;
              r_pc       <= w_req_plus4;
              r_req_addr <= w_req_plus4;
            end
          end else if (!Stall) begin
            r_valid_d <= 1'b0;
          end
        end
        S_HOLD: begin
          if (PCSrc) begin
            r_pc       <= w_target;
            r_req_addr <= w_target;
            r_state    <= S_WAIT;
            r_req      <= 1'b1;
          end else if (!Stall) begin
            // In HOLD, PC still names the buffered word.
            r_instr_d  <= r_hold;
            r_pcd      <= r_pc;
            r_pcp4d    <= w_pc_plus4;
            r_valid_d  <= 1'b1;
            r_pc       <= w_pc_plus4;
            r_req_addr <= w_pc_plus4;
            r_state    <= S_WAIT;
            r_req      <= 1'b1;
          end
        end
        S_DROP: begin
          if (PCSrc) begin
            r_pc <= w_target;
          end
          if (IMemValid) begin
            // The stale word is discarded; fetch from the newest PC.
            r_req_addr <= PCSrc ? w_target : r_pc;
            r_state    <= S_WAIT;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign IMemReq   = r_req;
  assign IMemAddr  = r_req_addr;
  assign InstrD    = r_instr_d;
  assign PCD       = r_pcd;
  assign PCPlus4D  = r_pcp4d;
  assign ValidD    = r_valid_d;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vector table, hand-written corner sequences and a
// randomized run checked against an instruction-stream reference model.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_DROP = 2'd3;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst, Stall, PCSrc, IMemValid;
  logic [31:0] PCTarget, IMemRData;
  logic        IMemReq, ValidD;
  logic [31:0] IMemAddr, InstrD, PCD, PCPlus4D;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst(rst), .Stall(Stall), .PCSrc(PCSrc), .PCTarget(PCTarget),
    .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemValid(IMemValid),
    .IMemRData(IMemRData), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .ValidD(ValidD), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instruction memory contents: a fixed function of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h0001_0003) ^ 32'h5A00_0013;
  endfunction

  // ---------------- memory responder + driver ----------------
  int lat = 0;
  int cnt = 0;
  bit rand_lat = 1'b0;

  // One clock: inputs are set at the falling edge and outputs settle by posedge+1.
  // With auto_mem set, the responder raises IMemValid on the (lat+1)-th
  // request cycle. Otherwise v_in drives IMemValid directly.
  task automatic drive_cycle(input logic r, input logic s, input logic p,
                             input logic [31:0] t, input logic v_in, input bit auto_mem);
    logic        v;
    logic        pr_req;
    logic [31:0] pr_addr;
    @(negedge clk);
    v = v_in;
    if (auto_mem) begin
      v = 1'b0;
      if (IMemReq === 1'b1) begin
        if (cnt >= lat) begin
          v   = 1'b1;
          cnt = 0;
          if (rand_lat) lat = $urandom_range(0, 3);
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
    rst       = r;
    Stall     = s;
    PCSrc     = p;
    PCTarget  = t;
    IMemValid = v;
    IMemRData = v ? mem_word(IMemAddr) : $urandom;
    pr_req    = IMemReq;
    pr_addr   = IMemAddr;
    @(posedge clk);
    #1;
    // An unanswered request must stay up with the same address.
    if (pr_req === 1'b1 && !v && !r) begin
      check("req_held", {31'd0, IMemReq}, 32'd1);
      check("addr_stable", IMemAddr, pr_addr);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rst, stall, pcsrc;
    logic [31:0] tgt;
    logic        mvalid;
    logic [1:0]  st;
    logic        req;
    logic [31:0] addr;
    logic        vd;
    logic [31:0] pcd, p4;
    logic [1:0]  ichk;  // 0 don't care, 1 NOP, 2 mem_word(pcd)
  } vec_t;

  function automatic vec_t mk(input logic r, input logic s, input logic p, input logic [31:0] t,
                              input logic mv, input logic [1:0] st, input logic req,
                              input logic [31:0] addr, input logic vd, input logic [31:0] pcd,
                              input logic [31:0] p4, input logic [1:0] ichk);
    vec_t x;
    x.rst = r; x.stall = s; x.pcsrc = p; x.tgt = t; x.mvalid = mv;
    x.st = st; x.req = req; x.addr = addr; x.vd = vd; x.pcd = pcd; x.p4 = p4; x.ichk = ichk;
    return x;
  endfunction

  vec_t tbl[22];

  // ---------------- main test ----------------
  logic [31:0] exp_next;
  int          consumed, idle, stuck;
  bit          s_r, p_r;
  logic [31:0] t_r;

  initial begin
    rst = 1'b1; Stall = 1'b0; PCSrc = 1'b0; PCTarget = '0; IMemValid = 1'b0; IMemRData = '0;

    //              rst st pc tgt           mv  state    req addr          vd pcd           p4            ichk
    tbl[0]  = mk(1, 0, 0, 32'h0,        0,  ST_IDLE, 0, 32'h0,        0, 32'h0,        32'h0,        1);
    tbl[1]  = mk(0, 0, 0, 32'h0,        0,  ST_WAIT, 1, 32'h0,        0, 32'h0,        32'h0,        1);
    tbl[2]  = mk(0, 0, 0, 32'h0,        1,  ST_WAIT, 1, 32'h4,        1, 32'h0,        32'h4,        2);
    tbl[3]  = mk(0, 0, 0, 32'h0,        1,  ST_WAIT, 1, 32'h8,        1, 32'h4,        32'h8,        2);
    tbl[4]  = mk(0, 0, 0, 32'h0,        1,  ST_WAIT, 1, 32'hC,        1, 32'h8,        32'hC,        2);
    tbl[5]  = mk(0, 0, 0, 32'h0,        1,  ST_WAIT, 1, 32'h10,       1, 32'hC,        32'h10,       2);
    tbl[6]  = mk(0, 1, 0, 32'h0,        1,  ST_HOLD, 0, 32'h10,       1, 32'hC,        32'h10,       2);
    tbl[7]  = mk(0, 1, 0, 32'h0,        0,  ST_HOLD, 0, 32'h10,       1, 32'hC,        32'h10,       2);
    tbl[8]  = mk(0, 1, 0, 32'h0,        0,  ST_HOLD, 0, 32'h10,       1, 32'hC,        32'h10,       2);
    tbl[9]  = mk(0, 1, 0, 32'h0,        0,  ST_HOLD, 0, 32'h10,       1, 32'hC,        32'h10,       2);
    tbl[10] = mk(0, 0, 0, 32'h0,        0,  ST_WAIT, 1, 32'h14,       1, 32'h10,       32'h14,       2);
    tbl[11] = mk(0, 0, 0, 32'h0,        1,  ST_WAIT, 1, 32'h18,       1, 32'h14,       32'h18,       2);
    tbl[12] = mk(0, 1, 0, 32'h0,        1,  ST_HOLD, 0, 32'h18,       1, 32'h14,       32'h18,       2);
    tbl[13] = mk(0, 1, 1, 32'h200,      0,  ST_WAIT, 1, 32'h200,      0, 32'h14,       32'h18,       1);
    tbl[14] = mk(0, 0, 0, 32'h0,        1,  ST_WAIT, 1, 32'h204,      1, 32'h200,      32'h204,      2);
    tbl[15] = mk(0, 0, 1, 32'hFFFF_FFFF, 1, ST_WAIT, 1, 32'hFFFF_FFFC, 0, 32'h200,      32'h204,      1);
    tbl[16] = mk(0, 0, 0, 32'h0,        1,  ST_WAIT, 1, 32'h0,        1, 32'hFFFF_FFFC, 32'h0,        2);
    tbl[17] = mk(0, 0, 0, 32'h0,        1,  ST_WAIT, 1, 32'h4,        1, 32'h0,        32'h4,        2);
    tbl[18] = mk(0, 0, 0, 32'h0,        0,  ST_WAIT, 1, 32'h4,        0, 32'h0,        32'h4,        0);
    tbl[19] = mk(0, 0, 0, 32'h0,        1,  ST_WAIT, 1, 32'h8,        1, 32'h4,        32'h8,        2);
    tbl[20] = mk(1, 0, 0, 32'h0,        1,  ST_IDLE, 0, 32'h0,        0, 32'h0,        32'h0,        1);
    tbl[21] = mk(0, 0, 0, 32'h0,        0,  ST_WAIT, 1, 32'h0,        0, 32'h0,        32'h0,        1);

    for (int i = 0; i < 22; i++) begin
      drive_cycle(tbl[i].rst, tbl[i].stall, tbl[i].pcsrc, tbl[i].tgt, tbl[i].mvalid, 1'b0);
      check($sformatf("v%0d_state", i), {30'd0, dbg_state}, {30'd0, tbl[i].st});
      check($sformatf("v%0d_req", i), {31'd0, IMemReq}, {31'd0, tbl[i].req});
      check($sformatf("v%0d_addr", i), IMemAddr, tbl[i].addr);
      check($sformatf("v%0d_validd", i), {31'd0, ValidD}, {31'd0, tbl[i].vd});
      check($sformatf("v%0d_pcd", i), PCD, tbl[i].pcd);
      check($sformatf("v%0d_pcp4", i), PCPlus4D, tbl[i].p4);
      if (tbl[i].ichk == 2'd1) check($sformatf("v%0d_instr_nop", i), InstrD, NOP);
      if (tbl[i].ichk == 2'd2) check($sformatf("v%0d_instr", i), InstrD, mem_word(tbl[i].pcd));
    end

    // ---- 3-cycle latency: first word after 4 request cycles, then 1,0,0,0 ----
    rand_lat = 1'b0; lat = 3; cnt = 0;
    drive_cycle(1, 0, 0, 0, 0, 1);
    drive_cycle(0, 0, 0, 0, 0, 1);
    for (int i = 1; i <= 4; i++) begin
      drive_cycle(0, 0, 0, 0, 0, 1);
      check($sformatf("lat3_first_v%0d", i), {31'd0, ValidD}, (i == 4) ? 32'd1 : 32'd0);
    end
    for (int k = 1; k < 12; k++) begin
      drive_cycle(0, 0, 0, 0, 0, 1);
      check($sformatf("lat3_v%0d", k), {31'd0, ValidD}, (k % 4 == 0) ? 32'd1 : 32'd0);
      check($sformatf("lat3_req%0d", k), {31'd0, IMemReq}, 32'd1);
      if (k % 4 == 0) check($sformatf("lat3_pcd%0d", k), PCD, 32'(4 * (k / 4)));
    end

    // ---- redirect to 0x103 from PC=0x20, latency 2, PCSrc in first wait cycle ----
    lat = 0; cnt = 0;
    drive_cycle(1, 0, 0, 0, 0, 1);
    drive_cycle(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 20 && IMemAddr !== 32'h20; i++) drive_cycle(0, 0, 0, 0, 0, 1);
    check("redir_reach_0x20", IMemAddr, 32'h20);
    lat = 2;
    drive_cycle(0, 0, 1, 32'h0000_0103, 0, 1);
    check("redir_state_drop", {30'd0, dbg_state}, {30'd0, ST_DROP});
    check("redir_addr_stale", IMemAddr, 32'h20);
    check("redir_validd", {31'd0, ValidD}, 32'd0);
    check("redir_instr_nop", InstrD, NOP);
    drive_cycle(0, 0, 0, 0, 0, 1);
    check("redir_addr_still_stale", IMemAddr, 32'h20);
    drive_cycle(0, 0, 0, 0, 0, 1);
    check("redir_next_addr", IMemAddr, 32'h100);
    check("redir_validd_after_drop", {31'd0, ValidD}, 32'd0);
    drive_cycle(0, 0, 0, 0, 0, 1);
    drive_cycle(0, 0, 0, 0, 0, 1);
    check("redir_bubble", {31'd0, ValidD}, 32'd0);
    drive_cycle(0, 0, 0, 0, 0, 1);
    check("redir_target_valid", {31'd0, ValidD}, 32'd1);
    check("redir_target_pcd", PCD, 32'h100);
    check("redir_target_instr", InstrD, mem_word(32'h100));

    // ---- randomized run against the instruction-stream model ----
    // Model: decode must see the addresses start, start+4, ... in order, each
    // exactly once. Every redirect restarts the stream at the aligned target.
    rand_lat = 1'b1; lat = $urandom_range(0, 3); cnt = 0;
    drive_cycle(1, 0, 0, 0, 0, 1);
    exp_next = 32'h0; consumed = 0; idle = 0; stuck = 0;
    for (int i = 0; i < 3000; i++) begin
      s_r = ($urandom_range(0, 3) == 0);
      p_r = ($urandom_range(0, 19) == 0);
      t_r = $urandom;
      if (p_r) begin
        exp_next = t_r & 32'hFFFF_FFFC;
      end else if (ValidD === 1'b1 && !s_r) begin
        check("rnd_pcd", PCD, exp_next);
        check("rnd_instr", InstrD, mem_word(exp_next));
        check("rnd_pcp4", PCPlus4D, exp_next + 32'd4);
        exp_next = exp_next + 32'd4;
        consumed++;
        idle = 0;
      end else begin
        idle++;
      end
      if (idle > 200) begin
        stuck = 1;
        break;
      end
      drive_cycle(0, s_r, p_r, t_r, 0, 1);
    end
    check("rnd_not_stuck", stuck, 0);
    check("rnd_progress", {31'd0, consumed >= 100}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Watchdog: the test ends long before this time.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
